// File: rtl/lsu_mem_port.sv
// Load/store port: turns one decoded LDR/STR into a valid/ready memory request.
// Latency: request sampled in IDLE -> REQUESTING -> WAITING (+memory wait) -> DONE.
// Backpressure: valid holds with stable address/data until the matching ready or timeout.
module lsu_mem_port #(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);

   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;
   localparam logic [7:0] TIMEOUT_LIM  = 8'(TIMEOUT_CYCLES);
   // Bits of rs that land in the address; the rest are zero-filled or dropped.
   localparam int CW = (ADDR_BITS < DATA_BITS) ? ADDR_BITS : DATA_BITS;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REQUESTING = 2'd1,
      WAITING    = 2'd2,
      DONE       = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 op_rd_q, op_rd_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [DATA_BITS-1:0] wdata_q, wdata_d;
   logic                 rd_vld_q, rd_vld_d;
   logic                 wr_vld_q, wr_vld_d;
   logic [DATA_BITS-1:0] out_q, out_d;
   logic                 err_q, err_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] rs_addr;
   logic                 new_req;

   // Address operand resized to the memory address width.
   always_comb begin
      rs_addr         = '0;
      rs_addr[CW-1:0] = rs[CW-1:0];
   end

   // Next-state and registered-output computation for the four-state FSM.
   always_comb begin
      state_d  = state_q;
      op_rd_d  = op_rd_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_vld_d = rd_vld_q;
      wr_vld_d = wr_vld_q;
      out_d    = out_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      new_req  = enable && (core_state == CORE_REQUEST) &&
                 (decoded_mem_read_enable || decoded_mem_write_enable);
      case (state_q)
         IDLE: begin
            if (new_req) begin
               // A simultaneous read and write decode is treated as a load.
               op_rd_d = decoded_mem_read_enable;
               addr_d  = rs_addr;
               wdata_d = rt;
               state_d = REQUESTING;
            end
         end
         REQUESTING: begin
            rd_vld_d = op_rd_q;
            wr_vld_d = !op_rd_q;
            cnt_d    = '0;
            err_d    = 1'b0;
            state_d  = WAITING;
         end
         WAITING: begin
            // Completion is checked before timeout so a ready on the last cycle wins.
            if (op_rd_q && mem_read_ready) begin
               rd_vld_d = 1'b0;
               out_d    = mem_read_data;
               state_d  = DONE;
            end else if (!op_rd_q && mem_write_ready) begin
               wr_vld_d = 1'b0;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
                  rd_vld_d = 1'b0;
                  wr_vld_d = 1'b0;
                  err_d    = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            if (core_state == CORE_UPDATE) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         op_rd_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_vld_q <= 1'b0;
         wr_vld_q <= 1'b0;
         out_q    <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_rd_q  <= op_rd_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_vld_q <= rd_vld_d;
         wr_vld_q <= wr_vld_d;
         out_q    <= out_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign mem_read_valid    = rd_vld_q;
   assign mem_read_address  = addr_q;
   assign mem_write_valid   = wr_vld_q;
   assign mem_write_address = addr_q;
   assign mem_write_data    = wdata_q;
   assign lsu_state         = state_q;
   assign lsu_out           = out_q;
   assign lsu_error         = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a short timeout (4 cycles).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Expected values are hand-computed constants per scenario.
module tb_lsu_mem_port;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] core_state;
   logic       rd_en, wr_en;
   logic [7:0] rs, rt;
   logic       mem_read_valid, mem_write_valid;
   logic [7:0] mem_read_address, mem_write_address, mem_write_data;
   logic       mem_read_ready, mem_write_ready;
   logic [7:0] mem_read_data;
   logic [1:0] lsu_state;
   logic [7:0] lsu_out;
   logic       lsu_error;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] REQ = 3'b011;
   localparam logic [2:0] UPD = 3'b110;

   always #5 clk = ~clk;

   lsu_mem_port #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .enable                   (enable),
      .core_state               (core_state),
      .decoded_mem_read_enable  (rd_en),
      .decoded_mem_write_enable (wr_en),
      .rs                       (rs),
      .rt                       (rt),
      .mem_read_valid           (mem_read_valid),
      .mem_read_address         (mem_read_address),
      .mem_read_ready           (mem_read_ready),
      .mem_read_data            (mem_read_data),
      .mem_write_valid          (mem_write_valid),
      .mem_write_address        (mem_write_address),
      .mem_write_data           (mem_write_data),
      .mem_write_ready          (mem_write_ready),
      .lsu_state                (lsu_state),
      .lsu_out                  (lsu_out),
      .lsu_error                (lsu_error)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a request in IDLE, then drop the decode so only one op is taken.
   task automatic issue(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
      core_state = REQ; rd_en = r; wr_en = w; rs = a; rt = d;
      step();
      core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
      rs = 8'h00; rt = 8'h00; mem_read_ready = 1'b0; mem_read_data = 8'h00;
      mem_write_ready = 1'b0;
      step(); step();
      check("rst_state", 8'(lsu_state), 8'd0);
      check("rst_rvld", 8'(mem_read_valid), 8'd0);
      check("rst_wvld", 8'(mem_write_valid), 8'd0);
      check("rst_out", lsu_out, 8'h00);
      check("rst_err", 8'(lsu_error), 8'd0);
      reset = 1'b1;
      enable = 1'b1;
      step();

      // Load; ready arrives on the 4th WAITING cycle, which is also the timeout cycle.
      issue(1'b1, 1'b0, 8'h12, 8'h00);
      check("ld_requesting", 8'(lsu_state), 8'd1);
      check("ld_no_vld_yet", 8'(mem_read_valid), 8'd0);
      step();
      check("ld_waiting", 8'(lsu_state), 8'd2);
      check("ld_rvld", 8'(mem_read_valid), 8'd1);
      check("ld_addr", mem_read_address, 8'h12);
      check("ld_wvld", 8'(mem_write_valid), 8'd0);
      step(); step(); step();
      check("ld_wait_hold", 8'(mem_read_valid), 8'd1);
      mem_read_ready = 1'b1; mem_read_data = 8'hA5;
      step();
      mem_read_ready = 1'b0; mem_read_data = 8'h00;
      check("ld_done", 8'(lsu_state), 8'd3);
      check("ld_rvld_drop", 8'(mem_read_valid), 8'd0);
      check("ld_out", lsu_out, 8'hA5);
      check("ld_err", 8'(lsu_error), 8'd0);
      step();
      check("ld_done_hold", 8'(lsu_state), 8'd3);
      core_state = UPD;
      step();
      core_state = 3'b000;
      check("ld_idle", 8'(lsu_state), 8'd0);

      // Store; a read ready in the write phase must be ignored.
      issue(1'b0, 1'b1, 8'h40, 8'h7E);
      step();
      check("st_wvld", 8'(mem_write_valid), 8'd1);
      check("st_rvld", 8'(mem_read_valid), 8'd0);
      check("st_addr", mem_write_address, 8'h40);
      check("st_data", mem_write_data, 8'h7E);
      mem_read_ready = 1'b1;
      step();
      mem_read_ready = 1'b0;
      check("st_other_rdy", 8'(lsu_state), 8'd2);
      mem_write_ready = 1'b1;
      step();
      mem_write_ready = 1'b0;
      check("st_done", 8'(lsu_state), 8'd3);
      check("st_wvld_drop", 8'(mem_write_valid), 8'd0);
      check("st_out_keep", lsu_out, 8'hA5);
      core_state = UPD;
      step();
      core_state = 3'b000;
      check("st_idle", 8'(lsu_state), 8'd0);

      // Both decodes set: treated as a load.
      issue(1'b1, 1'b1, 8'h05, 8'h99);
      step();
      check("both_rvld", 8'(mem_read_valid), 8'd1);
      check("both_wvld", 8'(mem_write_valid), 8'd0);
      check("both_addr", mem_read_address, 8'h05);
      mem_read_ready = 1'b1; mem_read_data = 8'h3C;
      step();
      mem_read_ready = 1'b0;
      check("both_out", lsu_out, 8'h3C);
      core_state = UPD;
      step();
      core_state = 3'b000;

      // Timeout: no ready for 4 WAITING cycles.
      issue(1'b1, 1'b0, 8'h20, 8'h00);
      step();
      step(); step(); step();
      check("to_still_wait", 8'(lsu_state), 8'd2);
      check("to_vld_hold", 8'(mem_read_valid), 8'd1);
      step();
      check("to_done", 8'(lsu_state), 8'd3);
      check("to_vld_drop", 8'(mem_read_valid), 8'd0);
      check("to_err", 8'(lsu_error), 8'd1);
      check("to_out_keep", lsu_out, 8'h3C);
      core_state = UPD;
      step();
      core_state = 3'b000;
      check("to_err_hold_idle", 8'(lsu_error), 8'd1);

      // enable=0 blocks a new request.
      enable = 1'b0;
      core_state = REQ; rd_en = 1'b1; rs = 8'h11;
      step(); step();
      check("dis_state", 8'(lsu_state), 8'd0);
      check("dis_rvld", 8'(mem_read_valid), 8'd0);
      core_state = 3'b000; rd_en = 1'b0;
      enable = 1'b1;

      // Reset two cycles into WAITING.
      issue(1'b1, 1'b0, 8'h33, 8'h00);
      step();
      check("rw_err_cleared", 8'(lsu_error), 8'd0);
      step(); step();
      check("rw_waiting", 8'(lsu_state), 8'd2);
      #2 reset = 1'b0;
      #1;
      check("rw_rvld", 8'(mem_read_valid), 8'd0);
      check("rw_state", 8'(lsu_state), 8'd0);
      check("rw_addr", mem_read_address, 8'h00);
      check("rw_out", lsu_out, 8'h00);
      mem_read_ready = 1'b1; mem_read_data = 8'hEE;
      step();
      reset = 1'b1;
      step(); step();
      check("rw_idle_after", 8'(lsu_state), 8'd0);
      check("rw_no_complete", lsu_out, 8'h00);
      check("rw_no_vld", 8'(mem_read_valid), 8'd0);
      mem_read_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
